conv_mem_responder: RTL and testbench

//  Memory-side counterpart of the CONV engine. Serves image pixels on iaddr/idata and services

---
 rtl/conv_mem_responder.sv | 151 +++++++++++++++
 tb/tb_conv_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV engine: image ROM, two layer banks, start handshake and run status.
// Engine reads are combinational; the host dump port is registered with one cycle of latency.
module conv_mem_responder #(
  parameter int DW       = 20,
  parameter int AW       = 12,
  parameter int L1_DEPTH = 1024,
  parameter int TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          img_we,
  input  logic [AW-1:0] img_addr,
  input  logic [DW-1:0] img_wdata,
  input  logic [2:0]    dump_sel,
  input  logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  output logic          timeout,
  output logic          err,
  output logic [12:0]   l0_wcnt,
  output logic [10:0]   l1_wcnt
);

  localparam int            L1W    = $clog2(L1_DEPTH);
  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [2:0]    SEL_L0 = 3'b001;
  localparam logic [2:0]    SEL_L1 = 3'b011;
  localparam logic [AW-1:0] L1_LIM = AW'(L1_DEPTH);
  localparam logic [12:0]   L0_MAX = 13'(2 ** AW);
  localparam logic [10:0]   L1_MAX = 11'(L1_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_WAIT, S_RUN, S_DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] wait_cnt;
  logic          launch, wait_expired;

  logic [DW-1:0] img_mem [2**AW];
  logic [DW-1:0] l0_mem  [2**AW];
  logic [DW-1:0] l1_mem  [L1_DEPTH];

  logic          wr_l0, wr_l1, wr_bad, img_ok, img_wr, img_bad;
  logic [DW-1:0] dump_nxt;

  assign wr_l0   = cwr && busy && (csel == SEL_L0);
  assign wr_l1   = cwr && busy && (csel == SEL_L1) && (caddr_wr < L1_LIM);
  assign wr_bad  = cwr && !wr_l0 && !wr_l1;
  assign img_ok  = (state == S_IDLE) || (state == S_DONE);
  assign img_wr  = img_we && img_ok;
  assign img_bad = img_we && !img_ok;

  assign idata = img_mem[iaddr];

  always_comb begin
    cdata_rd = '0;
    if (crd) begin
      if (csel == SEL_L0)
        cdata_rd = l0_mem[caddr_rd];
      else if (csel == SEL_L1 && caddr_rd < L1_LIM)
        cdata_rd = l1_mem[caddr_rd[L1W-1:0]];
    end
  end

  always_comb begin
    dump_nxt = '0;
    if (dump_sel == SEL_L0)
      dump_nxt = l0_mem[dump_addr];
    else if (dump_sel == SEL_L1 && dump_addr < L1_LIM)
      dump_nxt = l1_mem[dump_addr[L1W-1:0]];
  end

  // Memories are deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (img_wr) img_mem[img_addr] <= img_wdata;
    if (wr_l0)  l0_mem[caddr_wr] <= cdata_wr;
    if (wr_l1)  l1_mem[caddr_wr[L1W-1:0]] <= cdata_wr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    ready        = 1'b0;
    done         = 1'b0;
    launch       = 1'b0;
    wait_expired = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        launch  = 1'b1;
        state_n = S_READY;
      end
      S_READY: begin
        ready   = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (busy) begin
          state_n = S_RUN;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          wait_expired = 1'b1;
          state_n      = S_IDLE;
        end
      end
      S_RUN: if (!busy) state_n = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      err       <= 1'b0;
      l0_wcnt   <= '0;
      l1_wcnt   <= '0;
      dump_data <= '0;
    end else begin
      wait_cnt  <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
      dump_data <= dump_nxt;
      if (wait_expired)     timeout <= 1'b1;
      if (wr_bad || img_bad) err    <= 1'b1;
      if (launch) begin
        l0_wcnt <= '0;
        l1_wcnt <= '0;
      end else begin
        if (wr_l0 && l0_wcnt != L0_MAX) l0_wcnt <= l0_wcnt + 13'd1;
        if (wr_l1 && l1_wcnt != L1_MAX) l1_wcnt <= l1_wcnt + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized bench for conv_mem_responder against an array/queue model of the banks and run status.
module tb_conv_mem_responder;
  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset, start, img_we, busy, cwr, crd;
  logic [AW-1:0] img_addr, dump_addr, iaddr, caddr_wr, caddr_rd;
  logic [DW-1:0] img_wdata, cdata_wr;
  logic [2:0]    dump_sel, csel;
  logic [DW-1:0] dump_data, idata, cdata_rd;
  logic          ready, done, timeout, err;
  logic [12:0]   l0_wcnt;
  logic [10:0]   l1_wcnt;

  always #5 clk = ~clk;

  conv_mem_responder dut (
    .clk(clk), .reset(reset), .start(start), .img_we(img_we), .img_addr(img_addr),
    .img_wdata(img_wdata), .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .done(done), .timeout(timeout), .err(err), .l0_wcnt(l0_wcnt), .l1_wcnt(l1_wcnt)
  );

  int vec_cnt = 0;
  int miscmp  = 0;

  logic [DW-1:0] img_m [4096];
  logic [DW-1:0] l0_m  [4096];
  logic [DW-1:0] l1_m  [1024];
  bit            l0_v  [4096];
  bit            l1_v  [1024];
  logic [AW-1:0] img_q[$], l0_q[$], l1_q[$];
  int            l0n = 0, l1n = 0;
  bit            m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] bank_rd(input logic [2:0] s, input logic [AW-1:0] a);
    if (s == 3'b001) return l0_m[a];
    if (s == 3'b011 && int'(a) < 1024) return l1_m[a[9:0]];
    return '0;
  endfunction

  function automatic bit known(input logic [2:0] s, input logic [AW-1:0] a);
    if (s == 3'b001) return l0_v[a];
    if (s == 3'b011) return (int'(a) >= 1024) ? 1'b1 : l1_v[a[9:0]];
    return 1'b1;
  endfunction

  task automatic model_write(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!busy) m_err = 1'b1;
    else if (s == 3'b001) begin
      l0_m[a] = d; l0_v[a] = 1'b1; l0_q.push_back(a);
      l0n = (l0n < 4096) ? l0n + 1 : 4096;
    end else if (s == 3'b011 && int'(a) < 1024) begin
      l1_m[a[9:0]] = d; l1_v[a[9:0]] = 1'b1; l1_q.push_back(a);
      l1n = (l1n < 1024) ? l1n + 1 : 1024;
    end else m_err = 1'b1;
  endtask

  task automatic model_reset;
    m_err = 1'b0; l0n = 0; l1n = 0;
  endtask

  // One engine/host cycle: drive, check combinational read, clock, check dump and status.
  task automatic run_cycle(input bit w, input logic [2:0] s, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input bit r, input logic [AW-1:0] ra,
                           input logic [2:0] ds, input logic [AW-1:0] da);
    logic [DW-1:0] exp_dump;
    bit            kd;
    cwr = w; csel = s; caddr_wr = wa; cdata_wr = wd;
    crd = r; caddr_rd = ra; dump_sel = ds; dump_addr = da;
    #1;
    if (!r) check("cdata_rd_idle", cdata_rd, 0);
    else if (known(s, ra)) check("cdata_rd", cdata_rd, bank_rd(s, ra));
    kd = known(ds, da);
    exp_dump = bank_rd(ds, da);
    tick;
    if (w) model_write(s, wa, wd);
    cwr = 1'b0; crd = 1'b0;
    if (kd) check("dump_data", dump_data, exp_dump);
    check("err", err, m_err);
    check("l0_wcnt", l0_wcnt, l0n);
    check("l1_wcnt", l1_wcnt, l1n);
  endtask

  function automatic logic [2:0] rand_sel;
    logic [2:0] t;
    int k = $urandom_range(0, 2);
    if (k == 0) return 3'b001;
    if (k == 1) return 3'b011;
    do t = 3'($urandom); while (t == 3'b001 || t == 3'b011);
    return t;
  endfunction

  function automatic logic [AW-1:0] rand_addr(input logic [2:0] s);
    if (s == 3'b001 && l0_q.size() > 0 && $urandom_range(0, 1) == 1)
      return l0_q[$urandom_range(0, l0_q.size() - 1)];
    if (s == 3'b011 && l1_q.size() > 0 && $urandom_range(0, 1) == 1)
      return l1_q[$urandom_range(0, l1_q.size() - 1)];
    if (s == 3'b011) return 12'($urandom_range(0, 1100));
    return 12'($urandom_range(0, 4095));
  endfunction

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n, dp;
    logic [2:0]    s, ds;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    reset = 1'b0; start = 1'b0; img_we = 1'b0; busy = 1'b0; cwr = 1'b0; crd = 1'b0;
    img_addr = '0; img_wdata = '0; dump_sel = '0; dump_addr = '0; iaddr = '0;
    caddr_wr = '0; caddr_rd = '0; cdata_wr = '0; csel = '0;
    repeat (3) tick;
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err", err, 0);
    check("rst_dump", dump_data, 0);
    check("rst_l0", l0_wcnt, 0);
    check("rst_l1", l1_wcnt, 0);
    reset = 1'b1;
    tick;

    // Image load in IDLE, then combinational reads
    for (int i = 0; i < 64; i++) begin
      a = (i == 0) ? 12'd65 : 12'($urandom_range(0, 4095));
      d = (i == 0) ? 20'h0A000 : 20'($urandom);
      img_we = 1'b1; img_addr = a; img_wdata = d;
      tick;
      img_m[a] = d; img_q.push_back(a);
    end
    img_we = 1'b0;
    iaddr = 12'd65; #1;
    check("idata_65", idata, img_m[65]);
    for (int i = 0; i < 20; i++) begin
      a = img_q[$urandom_range(0, img_q.size() - 1)];
      iaddr = a; #1;
      check("idata", idata, img_m[a]);
    end
    check("err_after_load", err, 0);

    // Handshake: ready one cycle after start, busy two cycles after start
    pulse_start;
    check("ready_hi", ready, 1);
    tick;
    check("ready_lo", ready, 0);
    busy = 1'b1;
    tick;
    check("timeout_run", timeout, 0);
    check("done_run", done, 0);

    // Directed L0 write then readback on both ports
    run_cycle(1, 3'b001, 12'd130, 20'h01234, 0, 12'd0, 3'b001, 12'd130);
    run_cycle(0, 3'b001, 12'd0, 20'h0, 1, 12'd130, 3'b001, 12'd130);
    check("l0_first", l0_wcnt, 1);
    // Out-of-range L1 address and invalid bank select
    run_cycle(1, 3'b011, 12'd1024, 20'hABCDE, 0, 12'd0, 3'b000, 12'd0);
    run_cycle(1, 3'b010, 12'd7, 20'h55555, 0, 12'd0, 3'b001, 12'd130);

    // Random engine traffic with concurrent dumps
    for (int i = 0; i < 400; i++) begin
      s = rand_sel();
      ds = rand_sel();
      run_cycle($urandom_range(0, 9) < 7, s, rand_addr(s), 20'($urandom),
                $urandom_range(0, 1) == 1, rand_addr(s), ds, rand_addr(ds));
    end

    busy = 1'b0;
    tick;
    check("done_pulse", done, 1);
    tick;
    check("done_clear", done, 0);
    check("l0_hold", l0_wcnt, l0n);

    // Timeout: busy never rises
    pulse_start;
    model_reset();
    m_err = 1'b1;
    check("l0_cleared", l0_wcnt, 0);
    check("l1_cleared", l1_wcnt, 0);
    n = 0; dp = 0;
    while (timeout !== 1'b1 && n < 40) begin
      if (done === 1'b1) dp++;
      tick;
      n++;
    end
    check("timeout_lat", n, 17);
    check("timeout_set", timeout, 1);
    check("timeout_nodone", dp, 0);

    // Full run to saturation
    pulse_start;
    model_reset();
    m_err = 1'b1;
    tick;
    busy = 1'b1;
    tick;
    for (int i = 0; i < 4100; i++) begin
      ds = rand_sel();
      run_cycle(1, 3'b001, 12'(i % 4096), 20'($urandom), 0, 12'd0, ds, rand_addr(ds));
    end
    for (int i = 0; i < 1026; i++)
      run_cycle(1, 3'b011, 12'(i % 1024), 20'($urandom), 0, 12'd0, 3'b011, 12'(i));
    busy = 1'b0;
    dp = 0;
    repeat (4) begin
      tick;
      if (done === 1'b1) dp++;
    end
    check("full_done_cnt", dp, 1);
    check("full_l0", l0_wcnt, 4096);
    check("full_l1", l1_wcnt, 1024);

    // Reset asserted mid-run
    pulse_start;
    tick;
    busy = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_l0", l0_wcnt, 0);
    check("mid_rst_l1", l1_wcnt, 0);
    check("mid_rst_dump", dump_data, 0);
    model_reset();
    busy = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    for (int i = 0; i < 24; i++) begin
      ds = (i % 2 == 0) ? 3'b001 : 3'b011;
      run_cycle(0, 3'b001, 12'd0, 20'h0, 1, rand_addr(3'b001), ds, rand_addr(ds));
    end

    // Image write outside IDLE/DONE is dropped and flagged
    pulse_start;
    tick;
    img_we = 1'b1; img_addr = 12'd65; img_wdata = ~img_m[65];
    tick;
    img_we = 1'b0;
    m_err = 1'b1;
    check("img_we_wait_err", err, 1);
    iaddr = 12'd65; #1;
    check("img_we_wait_keep", idata, img_m[65]);
    repeat (20) tick;

    // Engine write with busy low is dropped and flagged
    reset = 1'b0;
    tick;
    reset = 1'b1;
    model_reset();
    tick;
    check("err_clear", err, 0);
    run_cycle(1, 3'b001, 12'd5, ~l0_m[5], 0, 12'd0, 3'b001, 12'd5);
    run_cycle(0, 3'b001, 12'd0, 20'h0, 0, 12'd0, 3'b001, 12'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule
